mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM pipeline stage between the EX/MEM register and the MEM/WB register of the 5-stage MIPS core.
- Performs loads and stores (byte, halfword, word) over a req/ack data-memory port. Stalls upstream while an access is outstanding.
- Presents MemReadData, ALU result, rd and writeback control to the MEM/WB register. That register has no enable, so this stage emits bubbles (ctrl=00) while stalled.

Parameters:
- TIMEOUT, 16: max cycles to wait for dmem_ack after dmem_req rises. 0 disables the timeout.
- TO_W, $clog2(TIMEOUT+1): timeout counter width (derived, not overridden).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  instruction present from EX/MEM
- ex_alu_result  in  32  ALU result; byte address for memory ops
- ex_store_data  in  32  rt value for stores
- ex_rd  in  5  destination register
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store (mem_read and mem_write together is illegal, treated as load)
- ex_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- ex_unsigned  in  1  zero-extend loads (lbu/lhu)
- ex_wb_ctrl  in  2  {RegWrite, MemToReg}, passed through
- dmem_req  out  1  access request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  access complete; rdata valid in the same cycle
- dmem_rdata  in  32  read word
- mem_stall  out  1  hold PC/IF/ID/EX/MEM registers this cycle
- wb_mem_data  out  32  formatted load data to MEM/WB
- wb_alu_result  out  32  ALU result to MEM/WB
- wb_rd  out  5  rd to MEM/WB
- wb_ctrl  out  2  writeback control to MEM/WB, 00 = bubble
- wb_valid  out  1  wb_* carry a completed instruction
- misalign_exc  out  1  one-cycle pulse: misaligned or illegal-size access dropped
- bus_err  out  1  one-cycle pulse: access abandoned on timeout

Behaviour:
- FSM states: IDLE, ACCESS. Reset → IDLE, dmem_req=0, dmem_we=0, dmem_addr/be/wdata=0, internal capture regs and timeout counter=0.
- misalign_exc and bus_err are registered pulses, reset to 0. Combinational wb_* outputs reset to bubble: wb_valid=0, wb_ctrl=00.
- IDLE, non-memory op (ex_valid, neither read nor write): wb_* = ex_* combinationally, wb_mem_data=0, wb_valid=1, mem_stall=0. Zero added latency.
- IDLE, ex_valid=0: bubble (wb_valid=0, wb_ctrl=00), mem_stall=0.
- IDLE, memory op, aligned: mem_stall=1, bubble out.
  - Capture rd, alu_result, wb_ctrl, size, unsigned and addr[1:0] into internal regs.
  - Register dmem_req=1 with we, addr, be, wdata. Go to ACCESS.
- Alignment rules: half needs addr[0]=0; word needs addr[1:0]=00; size 11 always illegal.
- IDLE, memory op, misaligned or illegal: no request is issued. misalign_exc=1 next cycle, instruction dropped (bubble out), mem_stall=0.
- ACCESS, dmem_ack=0: mem_stall=1, bubble out, request signals held stable, counter increments.
- ACCESS, dmem_ack=1:
  - wb_* from the captured regs, with wb_mem_data formatted from dmem_rdata; wb_valid=1.
  - mem_stall=0 in this same cycle, so the next instruction advances.
  - Next state IDLE, dmem_req=0.
- Minimum memory-op latency: 2 cycles (accept, then ack). There are no back-to-back requests; dmem_req is low for at least one cycle between accesses.
- Timeout: TIMEOUT≠0 and counter reaches TIMEOUT-1 with no ack → bus_err pulse next cycle, dmem_req drops, bubble out, mem_stall=0 in that cycle, state IDLE.
- dmem_ack while dmem_req=0 is ignored.
- Byte enables: byte → 4'b0001<<addr[1:0]; half → 4'b0011<<addr[1:0]; word → 4'b1111.
- Store data: byte replicated ×4, half replicated ×2, word unchanged.
- Load formatting: shift dmem_rdata right by 8*addr[1:0], take 8/16/32 bits, then sign- or zero-extend per unsigned.
- Stores: wb_ctrl passes through unchanged; decode supplies RegWrite=0. wb_mem_data=0.
- Reset mid-ACCESS: dmem_req drops immediately (async) and the instruction is lost.
- The memory side must tolerate an abandoned request.

Decomposition:
- Package mips_mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum IDLE/ACCESS;
  - wb_ctrl bit indices (WB_REGWRITE=1, WB_MEMTOREG=0).
- Sub-module mem_lane_align (combinational):
  - store side: be and wdata generation;
  - load side: extract and extend;
  - misalign detect.
- It is reused by a future cache.

Test Plan:
- lw addr 0x100, ack on 3rd cycle after accept with rdata 0xDEADBEEF → dmem_be=1111, mem_stall high 3 cycles, wb_mem_data=0xDEADBEEF, wb_valid=1 on the ack cycle.
- lb addr 0x103, rdata 0x80FF_0000 → be=1000, wb_mem_data=0xFFFFFF80. Repeat as lbu → 0x00000080.
- sh addr 0x202, data 0x1234ABCD, immediate ack → be=1100, wdata=0xABCDABCD, dmem_we=1, stall exactly 1 cycle.
- lw addr 0x102 → no dmem_req, misalign_exc pulse, bubble (wb_ctrl=00), mem_stall=0. Same result for ex_size=11.
- No ack with TIMEOUT=4 → dmem_req high 4 cycles, bus_err pulse, state IDLE, next ALU op passes with wb_valid=1.
- rst asserted mid-ACCESS → dmem_req=0 without a clock edge. After release, an add (rd=5, alu 0x7) passes the same cycle: wb_rd=5, wb_alu_result=0x7.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states and
// writeback-control bit positions.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Bit positions inside the 2-bit {RegWrite, MemToReg} writeback control.
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit little-endian data port: store-side byte
// enables and lane-replicated write data, load-side extract and extend, and
// alignment checking. Purely combinational so a cache can reuse it.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] shifted;

  // One enable per byte lane: a byte hits its own lane, a half hits the lane
  // pair selected by addr_lo[1], a word hits all four. Illegal size hits none.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign be[gi] = (size == SZ_WORD) ||
                      ((size == SZ_HALF) && (addr_lo[1] == LANE[1])) ||
                      ((size == SZ_BYTE) && (addr_lo == LANE));
    end
  endgenerate

  // Replicate store data across lanes so the enables alone pick the target.
  always_comb begin
    wdata = store_data;
    case (size)
      SZ_BYTE: wdata = {4{store_data[7:0]}};
      SZ_HALF: wdata = {2{store_data[15:0]}};
      default: wdata = store_data;
    endcase
  end

  // Bring the addressed lane down to bit 0, then sign- or zero-extend.
  always_comb begin
    shifted   = rdata >> {addr_lo, 3'b000};
    load_data = shifted;
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'd0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = is_unsigned ? {16'd0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Halves need even addresses, words need 4-byte alignment, size 11 never valid.
  always_comb begin
    misaligned = 1'b1;
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr_lo[0];
      SZ_WORD: misaligned = |addr_lo;
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores over a req/ack port, stalls the
// front of the pipe while an access is outstanding and feeds an
// enable-less MEM/WB register, so it emits bubbles while stalled.
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [1:0]  ex_wb_ctrl,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] wb_mem_data,
  output logic [31:0] wb_alu_result,
  output logic [4:0]  wb_rd,
  output logic [1:0]  wb_ctrl,
  output logic        wb_valid,
  output logic        misalign_exc,
  output logic        bus_err
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  // With the timeout disabled TO_W is 0; keep a 1-bit counter that is never used.
  localparam int CNT_W = (TO_W < 1) ? 1 : TO_W;

  state_t            state_reg, state_next;
  logic [4:0]        rd_reg;
  logic [31:0]       alu_reg;
  logic [1:0]        ctrl_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;
  logic [1:0]        addr_lo_reg;
  logic [CNT_W-1:0]  to_cnt_reg;

  logic              mem_op;
  logic              accept;
  logic              misalign_hit;
  logic              timeout_hit;
  logic              timeout_fire;

  logic [1:0]        align_size;
  logic [1:0]        align_addr_lo;
  logic              align_uns;
  logic [3:0]        align_be;
  logic [31:0]       align_wdata;
  logic [31:0]       align_load;
  logic              align_misaligned;

  // Read+write together is treated as a load, so either flag makes it a memory op.
  assign mem_op = ex_mem_read | ex_mem_write;

  assign timeout_hit = (TIMEOUT != 0) && (to_cnt_reg == CNT_W'(TIMEOUT - 1));

  // While waiting, the lane logic must format against the captured access,
  // not whatever sits in EX/MEM.
  assign align_size    = (state_reg == ACCESS) ? size_reg    : ex_size;
  assign align_addr_lo = (state_reg == ACCESS) ? addr_lo_reg : ex_alu_result[1:0];
  assign align_uns     = (state_reg == ACCESS) ? uns_reg     : ex_unsigned;

  mem_lane_align u_lane (
    .size        (align_size),
    .addr_lo     (align_addr_lo),
    .is_unsigned (align_uns),
    .store_data  (ex_store_data),
    .rdata       (dmem_rdata),
    .be          (align_be),
    .wdata       (align_wdata),
    .load_data   (align_load),
    .misaligned  (align_misaligned)
  );

  // Next state, stall and MEM/WB outputs; bubble whenever in reset.
  always_comb begin
    state_next    = state_reg;
    mem_stall     = 1'b0;
    wb_valid      = 1'b0;
    wb_ctrl       = 2'b00;
    wb_rd         = 5'd0;
    wb_alu_result = 32'd0;
    wb_mem_data   = 32'd0;
    accept        = 1'b0;
    misalign_hit  = 1'b0;
    timeout_fire  = 1'b0;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          if (ex_valid && !mem_op) begin
            wb_valid      = 1'b1;
            wb_ctrl       = ex_wb_ctrl;
            wb_rd         = ex_rd;
            wb_alu_result = ex_alu_result;
          end else if (ex_valid && align_misaligned) begin
            misalign_hit = 1'b1;
          end else if (ex_valid) begin
            accept     = 1'b1;
            mem_stall  = 1'b1;
            state_next = ACCESS;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            wb_valid      = 1'b1;
            wb_ctrl       = ctrl_reg;
            wb_rd         = rd_reg;
            wb_alu_result = alu_reg;
            wb_mem_data   = dmem_we ? 32'd0 : align_load;
            state_next    = IDLE;
          end else if (timeout_hit) begin
            // Abandon the access; releasing the stall lets the pipe move on.
            timeout_fire = 1'b1;
            state_next   = IDLE;
          end else begin
            mem_stall = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register, request/capture registers, timeout counter and exception pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      rd_reg       <= 5'd0;
      alu_reg      <= 32'd0;
      ctrl_reg     <= 2'b00;
      size_reg     <= 2'b00;
      uns_reg      <= 1'b0;
      addr_lo_reg  <= 2'b00;
      to_cnt_reg   <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'd0;
      dmem_be      <= 4'd0;
      dmem_wdata   <= 32'd0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      misalign_exc <= misalign_hit;
      bus_err      <= timeout_fire;
      if (accept) begin
        rd_reg      <= ex_rd;
        alu_reg     <= ex_alu_result;
        ctrl_reg    <= ex_wb_ctrl;
        size_reg    <= ex_size;
        uns_reg     <= ex_unsigned;
        addr_lo_reg <= ex_alu_result[1:0];
        to_cnt_reg  <= '0;
        dmem_req    <= 1'b1;
        dmem_we     <= ex_mem_write & ~ex_mem_read;
        dmem_addr   <= {ex_alu_result[31:2], 2'b00};
        dmem_be     <= align_be;
        dmem_wdata  <= align_wdata;
      end else if (state_reg == ACCESS) begin
        if (dmem_ack || timeout_fire) begin
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
        end else if (TIMEOUT != 0) begin
          to_cnt_reg <= to_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a short timeout. Inputs change
// 1 ns after the rising edge; outputs are sampled 4 ns after the edge.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic [1:0]  ex_wb_ctrl;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [31:0] wb_mem_data;
  logic [31:0] wb_alu_result;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_ctrl;
  logic        wb_valid;
  logic        misalign_exc;
  logic        bus_err;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_wb_ctrl(ex_wb_ctrl),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .wb_mem_data(wb_mem_data), .wb_alu_result(wb_alu_result),
    .wb_rd(wb_rd), .wb_ctrl(wb_ctrl), .wb_valid(wb_valid),
    .misalign_exc(misalign_exc), .bus_err(bus_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] rd, input logic rdm, input logic wrm,
                       input logic [1:0] sz, input logic uns, input logic [1:0] ctrl);
    ex_valid = v; ex_alu_result = alu; ex_store_data = sd; ex_rd = rd;
    ex_mem_read = rdm; ex_mem_write = wrm; ex_size = sz; ex_unsigned = uns;
    ex_wb_ctrl = ctrl;
  endtask

  task automatic test_reset();
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    step(); step(); #3;
    tests_run++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin
      tests_failed++; $display("FAIL reset_req: req=%b we=%b want 0 0", dmem_req, dmem_we);
    end
    tests_run++;
    if (dmem_addr !== 32'd0 || dmem_be !== 4'd0 || dmem_wdata !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_bus: addr=%h be=%b wdata=%h want 0", dmem_addr, dmem_be, dmem_wdata);
    end
    tests_run++;
    if (misalign_exc !== 1'b0 || bus_err !== 1'b0 || wb_valid !== 1'b0 || wb_ctrl !== 2'b00 ||
        mem_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out: mexc=%b berr=%b wbv=%b ctrl=%b stall=%b want all 0",
               misalign_exc, bus_err, wb_valid, wb_ctrl, mem_stall);
    end
    step(); rst = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_alu_pass();
    step();
    drive(1'b1, 32'h0000_1234, 32'd0, 5'd3, 1'b0, 1'b0, 2'b10, 1'b0, 2'b10); #3;
    tests_run++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_alu_result !== 32'h1234 ||
        wb_ctrl !== 2'b10 || wb_mem_data !== 32'd0 || mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL alu_pass: v=%b rd=%0d alu=%h ctrl=%b md=%h stall=%b req=%b want 1 3 1234 10 0 0 0",
               wb_valid, wb_rd, wb_alu_result, wb_ctrl, wb_mem_data, mem_stall, dmem_req);
    end
    ex_valid = 1'b0; #1;
    tests_run++;
    if (wb_valid !== 1'b0 || wb_ctrl !== 2'b00 || mem_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL invalid_bubble: v=%b ctrl=%b stall=%b want 0 00 0", wb_valid, wb_ctrl, mem_stall);
    end
    $display("[TB] alu passthrough rd=3 alu=0x1234");
  endtask

  task automatic test_lw_wait();
    int stalls = 0;
    step();
    drive(1'b1, 32'h0000_0100, 32'd0, 5'd8, 1'b1, 1'b0, 2'b10, 1'b0, 2'b11); #3;
    if (mem_stall === 1'b1) stalls++;
    tests_run++;
    if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || wb_ctrl !== 2'b00) begin
      tests_failed++;
      $display("FAIL lw_accept: req=%b v=%b ctrl=%b want 0 0 00", dmem_req, wb_valid, wb_ctrl);
    end
    step(); #3;
    if (mem_stall === 1'b1) stalls++;
    tests_run++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_be !== 4'b1111 || dmem_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL lw_req: req=%b we=%b be=%b addr=%h want 1 0 1111 100",
               dmem_req, dmem_we, dmem_be, dmem_addr);
    end
    step(); #3;
    if (mem_stall === 1'b1) stalls++;
    step(); dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; #3;
    if (mem_stall === 1'b1) stalls++;
    tests_run++;
    if (wb_valid !== 1'b1 || wb_mem_data !== 32'hDEAD_BEEF || wb_rd !== 5'd8 ||
        wb_alu_result !== 32'h100 || wb_ctrl !== 2'b11) begin
      tests_failed++;
      $display("FAIL lw_data: v=%b md=%h rd=%0d alu=%h ctrl=%b want 1 deadbeef 8 100 11",
               wb_valid, wb_mem_data, wb_rd, wb_alu_result, wb_ctrl);
    end
    tests_run++;
    if (stalls != 3) begin
      tests_failed++; $display("FAIL lw_stall_cycles: got %0d want 3", stalls);
    end
    step(); dmem_ack = 1'b0; ex_valid = 1'b0; #3;
    tests_run++;
    if (dmem_req !== 1'b0) begin
      tests_failed++; $display("FAIL lw_req_drop: req=%b want 0", dmem_req);
    end
    $display("[TB] lw 0x100 -> 0x%h", 32'hDEAD_BEEF);
  endtask

  task automatic test_load(input string name, input logic [31:0] addr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] rdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_data);
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    step();
    drive(1'b1, addr, 32'd0, 5'd9, 1'b1, 1'b0, sz, uns, 2'b11); #3;
    step(); dmem_ack = 1'b1; dmem_rdata = rdata; #3;
    tests_run++;
    if (dmem_be !== exp_be || dmem_addr !== exp_addr || dmem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_req: be=%b addr=%h req=%b want %b %h 1", name, dmem_be, dmem_addr, dmem_req,
               exp_be, exp_addr);
    end
    tests_run++;
    if (wb_mem_data !== exp_data || wb_valid !== 1'b1 || mem_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_data: md=%h v=%b stall=%b want %h 1 0", name, wb_mem_data, wb_valid,
               mem_stall, exp_data);
    end
    step(); dmem_ack = 1'b0; ex_valid = 1'b0;
    $display("[TB] %s addr=0x%h -> 0x%h", name, addr, exp_data);
  endtask

  task automatic test_store(input string name, input logic [31:0] addr, input logic [1:0] sz,
                            input logic [31:0] sd, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
    int stalls = 0;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    step();
    drive(1'b1, addr, sd, 5'd0, 1'b0, 1'b1, sz, 1'b0, 2'b00); #3;
    if (mem_stall === 1'b1) stalls++;
    step(); dmem_ack = 1'b1; #3;
    if (mem_stall === 1'b1) stalls++;
    tests_run++;
    if (dmem_we !== 1'b1 || dmem_be !== exp_be || dmem_wdata !== exp_wdata || dmem_addr !== exp_addr) begin
      tests_failed++;
      $display("FAIL %s_bus: we=%b be=%b wdata=%h addr=%h want 1 %b %h %h", name, dmem_we, dmem_be,
               dmem_wdata, dmem_addr, exp_be, exp_wdata, exp_addr);
    end
    tests_run++;
    if (wb_valid !== 1'b1 || wb_mem_data !== 32'd0 || wb_ctrl !== 2'b00 || stalls != 1) begin
      tests_failed++;
      $display("FAIL %s_wb: v=%b md=%h ctrl=%b stalls=%0d want 1 0 00 1", name, wb_valid,
               wb_mem_data, wb_ctrl, stalls);
    end
    step(); dmem_ack = 1'b0; ex_valid = 1'b0;
    $display("[TB] %s addr=0x%h wdata=0x%h", name, addr, exp_wdata);
  endtask

  task automatic test_misalign(input string name, input logic [31:0] addr, input logic [1:0] sz);
    step();
    drive(1'b1, addr, 32'd0, 5'd4, 1'b1, 1'b0, sz, 1'b0, 2'b11); #3;
    tests_run++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || wb_ctrl !== 2'b00 || wb_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_drop: req=%b stall=%b ctrl=%b v=%b want 0 0 00 0", name, dmem_req,
               mem_stall, wb_ctrl, wb_valid);
    end
    step(); ex_valid = 1'b0; #3;
    tests_run++;
    if (misalign_exc !== 1'b1 || dmem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_exc: mexc=%b req=%b want 1 0", name, misalign_exc, dmem_req);
    end
    step(); #3;
    tests_run++;
    if (misalign_exc !== 1'b0) begin
      tests_failed++; $display("FAIL %s_pulse: mexc=%b want 0", name, misalign_exc);
    end
    $display("[TB] %s addr=0x%h size=%b dropped", name, addr, sz);
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    bit saw_release = 0;
    step();
    drive(1'b1, 32'h0000_0300, 32'd0, 5'd6, 1'b1, 1'b0, 2'b10, 1'b0, 2'b11); #3;
    for (int i = 0; i < 8; i++) begin
      step(); #3;
      if (dmem_req === 1'b1) req_cycles++;
      if (mem_stall === 1'b0) begin
        saw_release = 1;
        tests_run++;
        if (wb_valid !== 1'b0 || wb_ctrl !== 2'b00 || bus_err !== 1'b0) begin
          tests_failed++;
          $display("FAIL to_release: v=%b ctrl=%b berr=%b want 0 00 0", wb_valid, wb_ctrl, bus_err);
        end
        break;
      end
    end
    tests_run++;
    if (!saw_release || req_cycles != 4) begin
      tests_failed++;
      $display("FAIL to_req_cycles: got %0d released=%0d want 4 1", req_cycles, saw_release);
    end
    step();
    drive(1'b1, 32'h0000_0055, 32'd0, 5'd7, 1'b0, 1'b0, 2'b10, 1'b0, 2'b10); #3;
    tests_run++;
    if (bus_err !== 1'b1 || dmem_req !== 1'b0) begin
      tests_failed++; $display("FAIL to_bus_err: berr=%b req=%b want 1 0", bus_err, dmem_req);
    end
    tests_run++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_alu_result !== 32'h55 || mem_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_next_alu: v=%b rd=%0d alu=%h stall=%b want 1 7 55 0", wb_valid, wb_rd,
               wb_alu_result, mem_stall);
    end
    step(); ex_valid = 1'b0; #3;
    tests_run++;
    if (bus_err !== 1'b0) begin
      tests_failed++; $display("FAIL to_pulse: berr=%b want 0", bus_err);
    end
    $display("[TB] timeout lw 0x300 abandoned after %0d req cycles", req_cycles);
  endtask

  task automatic test_back_to_back();
    step();
    drive(1'b1, 32'h0000_0400, 32'd0, 5'd10, 1'b1, 1'b0, 2'b10, 1'b0, 2'b11); #3;
    step(); dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222; #3;
    tests_run++;
    if (wb_valid !== 1'b1 || wb_mem_data !== 32'h1111_2222) begin
      tests_failed++;
      $display("FAIL b2b_first: v=%b md=%h want 1 11112222", wb_valid, wb_mem_data);
    end
    // Ack left high with no request outstanding must be ignored.
    step(); dmem_rdata = 32'h3333_4444;
    drive(1'b1, 32'h0000_0404, 32'd0, 5'd11, 1'b1, 1'b0, 2'b10, 1'b0, 2'b11); #3;
    tests_run++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b1 || wb_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_gap: req=%b stall=%b v=%b want 0 1 0", dmem_req, mem_stall, wb_valid);
    end
    step(); #3;
    tests_run++;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h404 || wb_mem_data !== 32'h3333_4444 ||
        wb_rd !== 5'd11) begin
      tests_failed++;
      $display("FAIL b2b_second: req=%b addr=%h md=%h rd=%0d want 1 404 33334444 11",
               dmem_req, dmem_addr, wb_mem_data, wb_rd);
    end
    step(); dmem_ack = 1'b0; ex_valid = 1'b0;
    $display("[TB] back-to-back lw 0x400, 0x404");
  endtask

  task automatic test_reset_mid_access();
    step();
    drive(1'b1, 32'h0000_0500, 32'd0, 5'd12, 1'b1, 1'b0, 2'b10, 1'b0, 2'b11); #3;
    step(); #3;
    tests_run++;
    if (dmem_req !== 1'b1) begin
      tests_failed++; $display("FAIL rstmid_pre: req=%b want 1", dmem_req);
    end
    #1 rst = 1'b1; #1;
    tests_run++;
    if (dmem_req !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_async: req=%b want 0", dmem_req);
    end
    step(); rst = 1'b0;
    drive(1'b1, 32'h0000_0007, 32'd0, 5'd5, 1'b0, 1'b0, 2'b10, 1'b0, 2'b10); #3;
    tests_run++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_alu_result !== 32'h7 || mem_stall !== 1'b0 ||
        dmem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_add: v=%b rd=%0d alu=%h stall=%b req=%b want 1 5 7 0 0",
               wb_valid, wb_rd, wb_alu_result, mem_stall, dmem_req);
    end
    step(); ex_valid = 1'b0;
    $display("[TB] reset mid-access then add rd=5 alu=0x7");
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_lw_wait();
    test_load("lb",  32'h0000_0103, 2'b00, 1'b0, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80);
    test_load("lbu", 32'h0000_0103, 2'b00, 1'b1, 32'h80FF_0000, 4'b1000, 32'h0000_0080);
    test_load("lh",  32'h0000_0102, 2'b01, 1'b0, 32'h80FF_0000, 4'b1100, 32'hFFFF_80FF);
    test_load("lbu1", 32'h0000_0101, 2'b00, 1'b1, 32'h1234_5678, 4'b0010, 32'h0000_0056);
    test_store("sh", 32'h0000_0202, 2'b01, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
    test_store("sb", 32'h0000_0201, 2'b00, 32'h0000_0055, 4'b0010, 32'h5555_5555);
    test_store("sw", 32'h0000_0208, 2'b10, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    test_misalign("lw_mis", 32'h0000_0102, 2'b10);
    test_misalign("sz11",   32'h0000_0100, 2'b11);
    test_misalign("lh_mis", 32'h0000_0101, 2'b01);
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
